// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: 16-bit word-count header, then little-endian words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              START,
  input  logic [7:0]                        BYTE_IN,
  input  logic                              BYTE_VALID,
  output logic                              BYTE_READY,
  output logic                              WR_EN,
  output logic [$clog2(TAM_POSICIONES)-1:0] WR_ADDRESS,
  output logic [TAM_PALABRA-1:0]            WR_DATA,
  output logic                              CORE_HOLD,
  output logic                              DONE,
  output logic                              LOAD_ERROR
);

  localparam int AW = $clog2(TAM_POSICIONES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [1:0]  cnt_q;
  logic [23:0] asm_q;
  logic [AW-1:0]          wr_addr_q;
  logic [TAM_PALABRA-1:0] wr_data_q;
  logic        accept;
  logic        start_load;
  logic [15:0] len_full;
  logic [15:0] idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept     = BYTE_VALID && BYTE_READY;
  assign start_load = START && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_full   = {BYTE_IN, len_q[7:0]};
  assign idx_inc    = idx_q + 16'd1;
  assign WR_ADDRESS = wr_addr_q;
  assign WR_DATA    = wr_data_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    BYTE_READY = 1'b0;
    WR_EN      = 1'b0;
    CORE_HOLD  = 1'b0;
    DONE       = 1'b0;
    LOAD_ERROR = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        BYTE_READY = 1'b1;
        CORE_HOLD  = 1'b1;
        if (BYTE_VALID) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        BYTE_READY = 1'b1;
        CORE_HOLD  = 1'b1;
        if (BYTE_VALID) begin
          if (len_full == 16'd0)                       state_d = S_END;
          else if (32'(len_full) > 32'(TAM_POSICIONES)) state_d = S_ERROR;
          else                                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        BYTE_READY = 1'b1;
        CORE_HOLD  = 1'b1;
        if (BYTE_VALID && cnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        WR_EN     = 1'b1;
        CORE_HOLD = 1'b1;
        state_d   = (idx_inc == len_q) ? S_END : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        BYTE_READY = 1'b1;
        CORE_HOLD  = 1'b1;
        if (BYTE_VALID) state_d = (BYTE_IN == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        DONE = 1'b1;
        if (START) state_d = S_LEN_LO;
      end
      S_ERROR: begin
        LOAD_ERROR = 1'b1;
        CORE_HOLD  = 1'b1;
        if (START) state_d = S_LEN_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath; the write register is loaded on the 4th byte so it holds steady outside WRITE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else if (start_load) begin
      len_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      asm_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      case (state_q)
        S_LEN_LO: if (accept) len_q[7:0]  <= BYTE_IN;
        S_LEN_HI: if (accept) len_q[15:8] <= BYTE_IN;
        S_DATA: begin
          if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            asm_q <= {BYTE_IN, asm_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ BYTE_IN;
`endif
            if (cnt_q == 2'd3) begin
              wr_data_q <= {BYTE_IN, asm_q};
              wr_addr_q <= idx_q[AW-1:0];
            end
          end
        end
        S_WRITE: idx_q <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at stimulus time, a monitor pops them on WR_EN.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST, START, BYTE_VALID;
  logic [7:0]  BYTE_IN;
  logic        BYTE_READY, WR_EN, CORE_HOLD, DONE, LOAD_ERROR;
  logic [9:0]  WR_ADDRESS;
  logic [31:0] WR_DATA;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];
  logic [41:0] mon_e;
  logic [7:0]  run_xor;

  imem_loader #(.TAM_POSICIONES(DEPTH), .TAM_PALABRA(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .WR_EN(WR_EN), .WR_ADDRESS(WR_ADDRESS), .WR_DATA(WR_DATA),
    .CORE_HOLD(CORE_HOLD), .DONE(DONE), .LOAD_ERROR(LOAD_ERROR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write", WR_ADDRESS, WR_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if ({WR_ADDRESS, WR_DATA} !== mon_e) begin
          errors++;
          $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                   WR_ADDRESS, WR_DATA, mon_e[41:32], mon_e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge CLK); #1; end
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
    forever begin
      @(negedge CLK);
      if (BYTE_READY === 1'b1) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL byte_accept actual=timeout required=accept of %h", b);
      BYTE_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      BYTE_VALID = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START   = 1'b0;
    run_xor = 8'h00;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] data, input int gap);
    exp_q.push_back({addr, data});
    for (int i = 0; i < 4; i++) begin
      send_byte(data[8*i +: 8], gap);
      run_xor ^= data[8*i +: 8];
    end
  endtask

  // Leaves the loader in DONE for a well-formed stream.
  task automatic end_stream(input bit had_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor, 0);
`else
    if (had_data) begin @(posedge CLK); #1; end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, BYTE_READY, 0);
    check({tag, "_wr_en"}, WR_EN, 0);
    check({tag, "_addr"},  WR_ADDRESS, 0);
    check({tag, "_data"},  WR_DATA, 0);
    check({tag, "_hold"},  CORE_HOLD, 0);
    check({tag, "_done"},  DONE, 0);
    check({tag, "_err"},   LOAD_ERROR, 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; BYTE_VALID = 1'b0; BYTE_IN = 8'h00; run_xor = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;

    // Two-word program.
    pulse_start();
    check("start_hold", CORE_HOLD, 1);
    check("start_ready", BYTE_READY, 1);
    send_len(16'd2);
    send_word(10'd0, 32'h0000_0013, 0);
    check("latency_w0", WR_EN, 1);
    send_word(10'd1, 32'h0010_0093, 0);
    check("latency_w1", WR_EN, 1);
    end_stream(1);
    check("t1_done", DONE, 1);
    check("t1_hold", CORE_HOLD, 0);
    check("t1_ready", BYTE_READY, 0);
    check("t1_addr_hold", WR_ADDRESS, 10'd1);
    check("t1_data_hold", WR_DATA, 32'h0010_0093);

    // Empty program.
    pulse_start();
    check("t2_done_cleared", DONE, 0);
    send_len(16'd0);
    end_stream(0);
    check("t2_done", DONE, 1);
    check("t2_hold", CORE_HOLD, 0);

    // Oversize length.
    pulse_start();
    send_len(16'd1025);
    check("t3_err", LOAD_ERROR, 1);
    check("t3_ready", BYTE_READY, 0);
    check("t3_hold", CORE_HOLD, 1);
    BYTE_VALID = 1'b1; BYTE_IN = 8'h5A;
    repeat (3) @(posedge CLK);
    #1;
    BYTE_VALID = 1'b0;
    check("t3_err_sticky", LOAD_ERROR, 1);
    pulse_start();
    check("t3_err_cleared", LOAD_ERROR, 0);
    check("t3_relaunch_hold", CORE_HOLD, 1);
    check("t3_relaunch_ready", BYTE_READY, 1);

    // One word with gaps between bytes and an ignored START mid-word.
    send_len(16'd1);
    exp_q.push_back({10'd0, 32'h1122_3344});
    send_byte(8'h44, 1);
    send_byte(8'h33, 1);
    pulse_start();
    run_xor = 8'h44 ^ 8'h33;
    send_byte(8'h22, 1);
    send_byte(8'h11, 1);
    run_xor ^= 8'h22 ^ 8'h11;
    end_stream(1);
    check("t4_done", DONE, 1);
    check("t4_data", WR_DATA, 32'h1122_3344);

    // Reset mid-load, then a clean reload.
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_all_zero("midrst");
    RST = 1'b0;
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'hDDCC_BBAA, 0);
    end_stream(1);
    check("t5_done", DONE, 1);

    // Full capacity.
    pulse_start();
    send_len(16'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      send_word(10'(i), (32'(i) * 32'h0101_0101) ^ 32'hA500_005A, 0);
    end_stream(1);
    check("full_done", DONE, 1);
    check("full_err", LOAD_ERROR, 0);
    check("full_last_addr", WR_ADDRESS, 10'd1023);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'h0000_0013, 0);
    send_byte(8'h13, 0);
    check("chk_good_done", DONE, 1);
    pulse_start();
    send_len(16'd1);
    send_word(10'd0, 32'h0000_0013, 0);
    send_byte(8'h12, 0);
    check("chk_bad_err", LOAD_ERROR, 1);
    check("chk_bad_done", DONE, 0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction memory: fills the instruction store that the core fetches from combinationally.
- Receives a byte stream over a valid/ready handshake, for example from a UART receiver.
- Parses a length header, assembles little-endian 32-bit words and issues single-cycle writes into the instruction RAM write port.
- Holds the core off (CORE_HOLD) from START until the load completes.

Parameters:
TAM_POSICIONES, 1024, number of instruction words in the target memory (write address width = $clog2(TAM_POSICIONES))
TAM_PALABRA, 32, memory word width; fixed at 32 (4 bytes per word), other values unsupported

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  pulse; begins a load when in IDLE, DONE or ERROR; ignored in every other state
BYTE_IN  input  8  incoming stream byte
BYTE_VALID  input  1  BYTE_IN is valid
BYTE_READY  output  1  loader accepts a byte this cycle
WR_EN  output  1  instruction RAM write strobe, one cycle per word
WR_ADDRESS  output  $clog2(TAM_POSICIONES)  word address of the write
WR_DATA  output  32  assembled instruction word
CORE_HOLD  output  1  keeps the core stalled/reset while loading
DONE  output  1  load completed successfully; level
LOAD_ERROR  output  1  load aborted; level

Behaviour:
- Reset: every output is 0. State = IDLE. Word index, byte counter, length and assembly register are cleared.
- Handshake: a byte is consumed on a rising edge where BYTE_VALID && BYTE_READY.
- BYTE_READY=1 only in LEN_LO, LEN_HI, DATA and CHK; it is 0 in IDLE, WRITE, DONE and ERROR.
- Stream format:
  - Length N: a 16-bit word count, low byte first.
  - Data: N*4 bytes, each word least-significant byte first. The first data byte lands in WR_DATA[7:0].
- States and transitions:
  - IDLE: on START go to LEN_LO and set CORE_HOLD=1.
  - LEN_LO: on accept, latch N[7:0] and go to LEN_HI.
  - LEN_HI: on accept, latch N[15:8].
    - If N==0, go to DONE (or CHK when CHECKSUM_EN is defined).
    - If N>TAM_POSICIONES, go to ERROR.
    - Otherwise go to DATA.
  - DATA: accept bytes into the assembly shift register. On the 4th byte go to WRITE.
  - WRITE (exactly 1 cycle):
    - WR_EN=1, WR_ADDRESS=word index, WR_DATA=assembled word.
    - Index increments. If the new index equals N, go to DONE (or CHK); otherwise return to DATA.
  - DONE: DONE=1, CORE_HOLD=0. Hold until START or RST. START clears DONE and returns to LEN_LO.
  - ERROR: LOAD_ERROR=1, CORE_HOLD stays 1, no further writes. START clears the flag and goes to LEN_LO.
- Outputs outside WRITE:
  - WR_EN=0 outside WRITE.
  - WR_ADDRESS/WR_DATA hold their last values; they are only meaningful while WR_EN=1.
- Latency: the write strobe appears in the cycle immediately after the 4th byte of a word is accepted.
- Gaps: BYTE_VALID may drop at any point; the loader simply waits and has no timeout.
- Boundaries:
  - N==TAM_POSICIONES is legal; the last write goes to address TAM_POSICIONES-1 and the index never wraps.
  - START during LEN_LO/LEN_HI/DATA/WRITE/CHK is ignored.
  - RST mid-load returns to IDLE in the next cycle with CORE_HOLD=0. Words already written stay in memory; nothing is cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte is kept (header excluded), cleared at load start.
  - After the last WRITE (or directly after LEN_HI when N==0) the loader enters CHK and accepts one checksum byte.
  - If the checksum byte equals the running XOR, go to DONE; otherwise go to ERROR.
- Not defined: no CHK state, no checksum logic; the stream ends after the last data byte.

Test Plan:
- RST, START, stream 02 00 13 00 00 00 93 00 10 00 -> WR_EN pulses at addr 0 data 0x00000013, then addr 1 data 0x00100093; DONE=1 and CORE_HOLD=0 after the second write.
- START, stream 00 00 -> no WR_EN; DONE=1 two accepts after START.
- TAM_POSICIONES=1024, stream length 01 04 (N=1025) -> LOAD_ERROR=1, BYTE_READY=0, CORE_HOLD=1, no writes; a later START clears LOAD_ERROR.
- N=1 with BYTE_VALID toggled 1/0 every cycle -> exactly one WR_EN; WR_DATA matches the bytes in order; no byte is dropped or duplicated.
- RST asserted after 2 data bytes -> next cycle all outputs are 0 and state is IDLE; a new load after START writes addr 0 correctly.
- CHECKSUM_EN defined: data 13 00 00 00 followed by checksum 13 -> DONE=1; the same data with checksum 12 -> LOAD_ERROR=1.
